div_unit: RTL

Iterative radix-2 divider for the RV32IM M-extension ops DIV, DIVU, REM and REMU. It sits in the EX stage beside the ALU. Its RESULT feeds the EX-stage 2-to-1 result mux, which selects between the ALU output and the divider output. The hazard unit uses BUSY to stall the front of the pipeline while a division is in flight.

---
 rtl/div_unit_pkg.sv | 25 ++
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider and the ID-stage decode.
//   - OPCODE encodings for the M-extension divide ops
//   - divider FSM state encoding
//   - wrap-around conditional negate helper
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_OP  = 2'b00,
    DIVU_OP = 2'b01,
    REM_OP  = 2'b10,
    REMU_OP = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Two's-complement negate when n is set; wraps modulo 2^32.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem_i     : current partial remainder (W+1 bits)
//   dvd_msb_i : dividend bit shifted in this step
//   dvs_i     : divisor magnitude
//   rem_o     : next partial remainder
//   q_o       : quotient bit produced by this step
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic         dvd_msb_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W+1:0] shifted;
  logic [W:0]   diff;

  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    q_o     = (shifted >= {2'b00, dvs_i});
    // Only consumed when the subtract succeeds, so the top bit never matters.
    diff    = shifted[W:0] - {1'b0, dvs_i};
    rem_o   = q_o ? diff : shifted[W:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU.
//   CLK, RESET(async, active low)
//   START/OPCODE/DATA1/DATA2 : request, sampled only in IDLE
//   FLUSH                    : abort, forces IDLE, RESULT untouched
//   RESULT                   : registered result, valid while VALID
//   BUSY                     : high in RUN and DONE
//   VALID                    : one-cycle pulse in DONE
// Normal ops take 32 RUN steps; divide-by-zero and signed overflow go
// straight to DONE.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OPCODE,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             VALID
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [1:0]       op_q, op_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic             is_signed, a_neg, b_neg, div_zero, ovf, special;

  div_step #(.W(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    is_signed = ~OPCODE[0];
    a_neg     = is_signed & DATA1[WIDTH-1];
    b_neg     = is_signed & DATA2[WIDTH-1];
    div_zero  = (DATA2 == '0);
    ovf       = is_signed && (DATA1 == MIN_NEG) && (DATA2 == '1);
    special   = div_zero | ovf;
  end

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; FLUSH overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = special ? DONE : RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (FLUSH) state_d = IDLE;
  end

  // Outputs decoded from state
  always_comb begin
    BUSY  = (state_q == RUN) || (state_q == DONE);
    VALID = (state_q == DONE);
  end

  // Datapath
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    if (FLUSH) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (START) begin
          op_d   = OPCODE;
          qneg_d = is_signed & (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
          rneg_d = a_neg;
          dvd_d  = neg_if(DATA1, a_neg);
          dvs_d  = neg_if(DATA2, b_neg);
          rem_d  = '0;
          cnt_d  = '0;
          if (div_zero)  result_d = OPCODE[1] ? DATA1 : '1;
          else if (ovf)  result_d = OPCODE[1] ? '0 : MIN_NEG;
        end
        RUN: begin
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], step_q};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST)
            result_d = op_q[1] ? neg_if(step_rem[WIDTH-1:0], rneg_q)
                               : neg_if({dvd_q[WIDTH-2:0], step_q}, qneg_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign RESULT = result_q;

endmodule
